// File: rtl/pe_sched_pkg.sv
// Shared encodings and default geometry for the mapping-layer PE bank and its
// tap scheduler.
package pe_sched_pkg;

  localparam int unsigned PIX_W         = 24;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned DEF_N_TAP     = 6;
  localparam int unsigned DEF_DRAIN_CYC = 3;

  typedef enum logic [2:0] {
    StFlush,
    StFlWait,
    StTap,
    StDrain,
    StClr,
    StWaitRes,
    StOut
  } sched_state_e;

endpackage

// File: rtl/pe_tap_scheduler.sv
// Tap sequencer for one bank of lock-step PEs: broadcasts accepted pixels with a
// tap address, drains the DSP pipeline, clears the PEs and offers the results.
module pe_tap_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned N_PE      = 4,
  parameter int unsigned N_TAP     = DEF_N_TAP,
  parameter int unsigned DRAIN_CYC = DEF_DRAIN_CYC,
  parameter int unsigned RES_W     = 24,
  parameter int unsigned TIMEOUT   = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PIX_W-1:0]      s_pixel,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [PIX_W-1:0]      o_pe_pixel,
  output logic                  o_pe_en,
  output logic [ADDR_W-1:0]     o_pe_addr,
  output logic                  o_pe_clr,
  input  logic                  i_pe_valid,
  input  logic [N_PE*RES_W-1:0] i_pe_result,
  output logic [N_PE*RES_W-1:0] m_result,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 2);
  // The wait counter is zero in the clear-pulse cycle, so the limit sits one higher.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT + 1);

  sched_state_e             state_q, state_d;
  logic [ADDR_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic [DrainW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [WaitW-1:0]         wait_cnt_q, wait_cnt_d;

  logic                     s_ready_q, s_ready_d;
  logic [PIX_W-1:0]         pe_pixel_q, pe_pixel_d;
  logic                     pe_en_q, pe_en_d;
  logic [ADDR_W-1:0]        pe_addr_q, pe_addr_d;
  logic                     pe_clr_q, pe_clr_d;
  logic [N_PE*RES_W-1:0]    m_result_q, m_result_d;
  logic                     m_valid_q, m_valid_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  logic s_hs, m_hs, wait_done;

  assign s_hs      = s_valid & s_ready_q;
  assign m_hs      = m_valid_q & m_ready;
  assign wait_done = (wait_cnt_q == WaitLast);

  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pe_pixel_d  = '0;
    pe_en_d     = 1'b0;
    pe_addr_d   = '0;
    pe_clr_d    = 1'b0;
    m_result_d  = m_result_q;
    m_valid_d   = m_valid_q;
    err_d       = err_q;

    unique case (state_q)
      StFlush: begin
        pe_clr_d   = 1'b1;
        pe_en_d    = 1'b1;
        wait_cnt_d = '0;
        state_d    = StFlWait;
      end
      StFlWait: begin
        pe_en_d    = 1'b1;
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        // The flush result only proves the PEs are idle; it is discarded.
        if (i_pe_valid || wait_done) begin
          pe_en_d = 1'b0;
          state_d = StTap;
          if (!i_pe_valid) err_d = 1'b1;
        end
      end
      StTap: begin
        if (s_hs) begin
          pe_en_d    = 1'b1;
          pe_pixel_d = s_pixel;
          pe_addr_d  = tap_cnt_q;
          if (tap_cnt_q == ADDR_W'(N_TAP - 1)) begin
            tap_cnt_d   = '0;
            drain_cnt_d = '0;
            state_d     = StDrain;
          end else begin
            tap_cnt_d = tap_cnt_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        pe_en_d = 1'b1;
        if (drain_cnt_q == DrainW'(DRAIN_CYC - 1)) begin
          state_d = StClr;
        end else begin
          drain_cnt_d = drain_cnt_q + DrainW'(1);
        end
      end
      StClr: begin
        pe_clr_d   = 1'b1;
        pe_en_d    = 1'b1;
        wait_cnt_d = '0;
        state_d    = StWaitRes;
      end
      StWaitRes: begin
        pe_en_d    = 1'b1;
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if (i_pe_valid) begin
          pe_en_d    = 1'b0;
          m_result_d = i_pe_result;
          m_valid_d  = 1'b1;
          state_d    = StOut;
        end else if (wait_done) begin
          // Still emit a defined (zero) bundle so downstream never stalls forever.
          pe_en_d    = 1'b0;
          err_d      = 1'b1;
          m_result_d = '0;
          m_valid_d  = 1'b1;
          state_d    = StOut;
        end
      end
      StOut: begin
        if (m_hs) begin
          m_valid_d = 1'b0;
          state_d   = StTap;
        end
      end
      default: state_d = StFlush;
    endcase

    s_ready_d = (state_d == StTap);
    busy_d    = !((state_d == StTap) && (tap_cnt_d == '0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StFlush;
      tap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      s_ready_q   <= 1'b0;
      pe_pixel_q  <= '0;
      pe_en_q     <= 1'b0;
      pe_addr_q   <= '0;
      pe_clr_q    <= 1'b0;
      m_result_q  <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      s_ready_q   <= s_ready_d;
      pe_pixel_q  <= pe_pixel_d;
      pe_en_q     <= pe_en_d;
      pe_addr_q   <= pe_addr_d;
      pe_clr_q    <= pe_clr_d;
      m_result_q  <= m_result_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign o_pe_pixel = pe_pixel_q;
  assign o_pe_en    = pe_en_q;
  assign o_pe_addr  = pe_addr_q;
  assign o_pe_clr   = pe_clr_q;
  assign m_result   = m_result_q;
  assign m_valid    = m_valid_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_pe_tap_scheduler.sv
// Scoreboard bench for pe_tap_scheduler: a PE model answers each clear pulse,
// monitors check the tap bus, drain/clear sequence and result bundles.
module tb_pe_tap_scheduler;

  localparam int unsigned NTap   = 6;
  localparam int unsigned NDrain = 3;
  localparam logic [95:0] ValA = 96'hDDDDDD_CCCCCC_BBBBBB_AAAAAA;
  localparam logic [95:0] ValB = 96'h444444_333333_222222_111111;
  localparam logic [95:0] ValC = 96'h0000C4_0000C3_0000C2_0000C1;
  localparam logic [95:0] ValD = 96'h123456_789ABC_DEF012_345678;

  typedef struct {
    logic [95:0] res;
    int          lat;
    logic        err;
  } bundle_t;

  typedef struct {
    logic [23:0] pix;
    logic [2:0]  addr;
  } tap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] o_pe_pixel;
  logic        o_pe_en;
  logic [2:0]  o_pe_addr;
  logic        o_pe_clr;
  logic        i_pe_valid = 1'b0;
  logic [95:0] i_pe_result = '0;
  logic [95:0] m_result;
  logic        m_valid;
  logic        m_ready;
  logic        o_busy;
  logic        o_err;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_acc = 0;
  bundle_t     exp_q[$];
  tap_t        tap_q[$];
  bundle_t     mon_b;
  tap_t        mon_t;
  logic        mv_prev = 1'b0;
  logic        held_valid = 1'b0;
  logic [95:0] held_res = '0;
  logic        rdy_after = 1'b0;
  int          drain_k = 0;
  int          pe_cnt = 0;
  logic        pe_respond = 1'b1;
  logic [95:0] pe_value = '0;

  pe_tap_scheduler dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .s_pixel    (s_pixel),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .o_pe_pixel (o_pe_pixel),
    .o_pe_en    (o_pe_en),
    .o_pe_addr  (o_pe_addr),
    .o_pe_clr   (o_pe_clr),
    .i_pe_valid (i_pe_valid),
    .i_pe_result(i_pe_result),
    .m_result   (m_result),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // PE model: result valid three cycles after each clear pulse.
  always @(negedge clk) begin
    i_pe_valid = 1'b0;
    if (pe_cnt > 0) begin
      pe_cnt--;
      if (pe_cnt == 0 && pe_respond) begin
        i_pe_valid  = 1'b1;
        i_pe_result = pe_value;
      end
    end
    if (o_pe_clr) pe_cnt = 3;
  end

  // Handshakes are sampled at the clock edge, before registered outputs move.
  always @(posedge clk) begin
    if (s_valid && s_ready) last_acc = cyc;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("bundle_unexpected", 1, 0);
      end else begin
        mon_b = exp_q.pop_front();
        check("m_result", m_result, mon_b.res);
      end
      held_valid = 1'b0;
      rdy_after  = 1'b1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rdy_after) begin
      check("s_ready_after_out", s_ready, 1'b1);
      rdy_after = 1'b0;
    end
    if (m_valid && !mv_prev) begin
      if (exp_q.size() == 0) begin
        check("m_valid_unexpected", 1, 0);
      end else begin
        check("latency", cyc - last_acc, exp_q[0].lat);
        check("err_at_result", o_err, exp_q[0].err);
      end
    end
    if (m_valid) begin
      check("s_ready_in_out", s_ready, 1'b0);
      if (held_valid) check("m_result_hold", m_result, held_res);
      held_res   = m_result;
      held_valid = 1'b1;
    end else begin
      held_valid = 1'b0;
    end
    mv_prev = m_valid;

    if (drain_k > 0) begin
      check("drain_seq", {o_pe_en, o_pe_pixel, o_pe_addr, o_pe_clr},
            {1'b1, 24'h0, 3'h0, (drain_k == NDrain + 1)});
      drain_k = (drain_k == NDrain + 1) ? 0 : drain_k + 1;
    end
    if (o_pe_en && o_pe_pixel != 24'h0) begin
      if (tap_q.size() == 0) begin
        check("tap_unexpected", o_pe_pixel, 0);
      end else begin
        mon_t = tap_q.pop_front();
        check("tap_bus", {o_pe_clr, o_pe_addr, o_pe_pixel}, {1'b0, mon_t.addr, mon_t.pix});
        if (mon_t.addr == 3'(NTap - 1)) drain_k = 1;
      end
    end
    if (s_ready && o_pe_pixel == 24'h0) check("en_idle", o_pe_en, 1'b0);
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pix_of(input int i);
    return {8'(i + 1), 8'(i + 2), 8'(i + 3)};
  endfunction

  task automatic chk_zero(input string name);
    check(name, {s_ready, o_pe_pixel, o_pe_en, o_pe_addr, o_pe_clr, m_valid, o_busy, o_err}, 0);
    check(name, m_result, 0);
  endtask

  task automatic send_pixel(input logic [23:0] pix, input int addr);
    int n = 0;
    s_pixel = pix;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_wait", s_ready, 1'b1);
    tap_q.push_back('{pix: pix, addr: 3'(addr)});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_bundle(input int gap_after);
    for (int i = 0; i < NTap; i++) begin
      send_pixel(pix_of(i), i);
      if (i == gap_after) begin
        repeat (4) @(negedge clk);
        check("busy_stall", o_busy, 1'b1);
      end
    end
  endtask

  task automatic wait_bundle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bundle_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_pixel = '0;
    m_ready = 1'b1;
    pe_value = ValA;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;

    // Flush pulse, then TAP once the PE answers.
    @(negedge clk);
    check("flush_clr", {o_pe_clr, o_pe_en, o_pe_pixel}, {1'b1, 1'b1, 24'h0});
    @(negedge clk);
    check("flush_clr_once", o_pe_clr, 1'b0);
    n = 1;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("flush_to_ready", n, 4);
    check("idle_flags", {o_err, m_valid, o_busy}, 3'b000);

    exp_q.push_back('{res: ValA, lat: 9, err: 1'b0});
    send_bundle(-1);
    wait_bundle();

    exp_q.push_back('{res: ValA, lat: 9, err: 1'b0});
    send_bundle(2);
    wait_bundle();

    pe_value = ValB;
    m_ready  = 1'b0;
    exp_q.push_back('{res: ValB, lat: 9, err: 1'b0});
    send_bundle(-1);
    n = 0;
    while (!m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("m_valid_wait", m_valid, 1'b1);
    repeat (10) @(negedge clk);
    m_ready = 1'b1;
    wait_bundle();

    // PE silent: zero bundle after the timeout, error sticks.
    pe_respond = 1'b0;
    exp_q.push_back('{res: 96'h0, lat: 14, err: 1'b1});
    send_bundle(-1);
    wait_bundle();
    check("err_sticky", o_err, 1'b1);
    pe_respond = 1'b1;
    pe_value   = ValC;
    exp_q.push_back('{res: ValC, lat: 9, err: 1'b1});
    send_bundle(-1);
    wait_bundle();

    // Reset while draining: bundle dropped, flush, clean restart.
    send_bundle(-1);
    @(negedge clk);
    drain_k = 0;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset_in_drain");
    rst = 1'b0;
    @(negedge clk);
    check("reset_flush_clr", {o_pe_clr, o_pe_en}, 2'b11);
    pe_value = ValD;
    exp_q.push_back('{res: ValD, lat: 9, err: 1'b0});
    send_bundle(-1);
    wait_bundle();

    check("tap_q_empty", tap_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
